testdata_check_valid: RTL



---
 rtl/testdata_check_valid.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/testdata_check_valid.sv
// testdata_check_valid: read-side checker for the DDR3 test top.
// Requests words from the read FIFO and checks each rd_valid word against the
// incrementing pattern written by the generator. It counts mismatches and
// completed passes, and reports done/pass status for ILA or LED observation.
// Optional build macro: CHK_FIRST_ERR_CAPTURE_EN adds capture ports for the first mismatch.
module testdata_check_valid #(
    parameter int unsigned                FIFO_RD_WIDTH  = 32,
    parameter int unsigned                WORDS_PER_PASS = 2048,
    parameter int unsigned                NUM_PASSES     = 4,
    parameter logic [FIFO_RD_WIDTH-1:0]   PAT_START      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     calib_done,
    input  logic                     rd_mem_enable,
    input  logic [FIFO_RD_WIDTH-1:0] rd_data,
    input  logic                     rd_valid,
    output logic                     rd_en,
    output logic                     err_flag,
    output logic [15:0]              err_cnt,
    output logic [15:0]              pass_cnt,
    output logic                     test_done,
    output logic                     test_pass
`ifdef CHK_FIRST_ERR_CAPTURE_EN
    ,
    output logic [FIFO_RD_WIDTH-1:0] first_err_data,
    output logic [FIFO_RD_WIDTH-1:0] first_err_exp,
    output logic [31:0]              first_err_idx
`endif
);

    localparam int unsigned WCNT_W = (WORDS_PER_PASS > 1) ? $clog2(WORDS_PER_PASS) : 1;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [FIFO_RD_WIDTH-1:0] expected;
    logic [FIFO_RD_WIDTH-1:0] expected_nxt;
    logic [WCNT_W-1:0]        word_cnt;
    logic [WCNT_W-1:0]        word_cnt_nxt;
    logic [CNT_W-1:0]         pass_cnt_nxt;
    logic [CNT_W-1:0]         err_cnt_nxt;
    logic                     err_flag_nxt;
    logic                     rd_en_nxt;
    logic                     test_done_nxt;
    logic                     test_pass_nxt;
    logic                     mismatch_c;
    logic                     passes_reached_c;

    // Compare datapath, pass/error counters and next-state decode
    always_comb begin
        expected_nxt     = expected;
        word_cnt_nxt     = word_cnt;
        pass_cnt_nxt     = pass_cnt;
        err_cnt_nxt      = err_cnt;
        err_flag_nxt     = err_flag;
        mismatch_c       = 1'b0;
        state_nxt        = state;
        passes_reached_c = 1'b0;

        // Valid words are checked in every state so in-flight data is never lost
        if (rd_valid) begin
            mismatch_c = (rd_data != expected);
            if (word_cnt == WCNT_W'(WORDS_PER_PASS - 1)) begin
                word_cnt_nxt = '0;
                expected_nxt = PAT_START;
                if (pass_cnt != '1) begin
                    pass_cnt_nxt = pass_cnt + CNT_W'(1);
                end
            end else begin
                word_cnt_nxt = word_cnt + WCNT_W'(1);
                expected_nxt = expected + FIFO_RD_WIDTH'(1);
            end
            if (mismatch_c) begin
                err_flag_nxt = 1'b1;
                if (err_cnt != '1) begin
                    err_cnt_nxt = err_cnt + CNT_W'(1);
                end
            end
        end

        passes_reached_c = (NUM_PASSES != 0) && (32'(pass_cnt_nxt) >= 32'(NUM_PASSES));

        case (state)
            S_IDLE: if (calib_done) state_nxt = S_WAIT;
            S_WAIT: if (calib_done && rd_mem_enable) state_nxt = S_READ;
            S_READ: begin
                if (passes_reached_c) begin
                    state_nxt = S_DONE;
                end else if (!calib_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase

        rd_en_nxt     = (state_nxt == S_READ);
        test_done_nxt = (state_nxt == S_DONE);
        test_pass_nxt = test_done_nxt && !err_flag_nxt;
    end

    // State, pattern tracking and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            expected  <= PAT_START;
            word_cnt  <= '0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            rd_en     <= 1'b0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
        end else begin
            state     <= state_nxt;
            expected  <= expected_nxt;
            word_cnt  <= word_cnt_nxt;
            pass_cnt  <= pass_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            err_flag  <= err_flag_nxt;
            rd_en     <= rd_en_nxt;
            test_done <= test_done_nxt;
            test_pass <= test_pass_nxt;
        end
    end

`ifdef CHK_FIRST_ERR_CAPTURE_EN
    logic [31:0] word_idx;

    // Global valid-word index and capture of the first mismatching word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx       <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            first_err_idx  <= '0;
        end else if (rd_valid) begin
            word_idx <= word_idx + 32'd1;
            if (mismatch_c && !err_flag) begin
                first_err_data <= rd_data;
                first_err_exp  <= expected;
                first_err_idx  <= word_idx;
            end
        end
    end
`endif

endmodule
